// File: rtl/led_pattern_sequencer_if.sv
// Pad/counter-side signals of the LED pattern sequencer.
// Optional Hold input is present when LED_SEQ_HOLD_EN is defined.
interface led_pattern_sequencer_if;
   logic [31:0] CSCounter;
   logic        ModeButton;
`ifdef LED_SEQ_HOLD_EN
   logic        Hold;
`endif
   logic        LED1;
   logic        LED2;
   logic        LED3;
   logic        LED4;
   logic [1:0]  Mode;

   modport slave (
`ifdef LED_SEQ_HOLD_EN
      input  Hold,
`endif
      input  CSCounter,
      input  ModeButton,
      output LED1,
      output LED2,
      output LED3,
      output LED4,
      output Mode
   );

   modport master (
`ifdef LED_SEQ_HOLD_EN
      output Hold,
`endif
      output CSCounter,
      output ModeButton,
      input  LED1,
      input  LED2,
      input  LED3,
      input  LED4,
      input  Mode
   );
endinterface

// File: rtl/led_pattern_sequencer.sv
// Drives four LEDs with BINARY/CHASE/BOUNCE/BREATHE patterns stepped by a CSCounter bit edge.
// Define LED_SEQ_HOLD_EN to add the Hold input that freezes pattern stepping.
module led_pattern_sequencer #(
   parameter int unsigned TICK_BIT        = 20,
   parameter int unsigned PWM_BITS        = 8,
   parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
   input logic                    Clock,
   input logic                    Reset,
   led_pattern_sequencer_if.slave bus
);
   localparam int unsigned       CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

   typedef enum logic [1:0] {
      MODE_BINARY  = 2'd0,
      MODE_CHASE   = 2'd1,
      MODE_BOUNCE  = 2'd2,
      MODE_BREATHE = 2'd3
   } mode_e;

   logic                r_tick_prev;
   logic                r_sync1;
   logic                r_sync2;
   logic                r_db_level;
   logic [CNT_W-1:0]    r_db_cnt;
   mode_e               r_mode;
   logic [3:0]          r_step;
   logic [3:0]          r_onehot;
   logic                r_dir_down;
   logic [PWM_BITS-1:0] r_duty;
   logic [3:0]          r_led;

   logic                w_tick;
   logic                w_tick_eff;
   logic                w_db_diff;
   logic                w_db_accept;
   logic                w_mode_adv;
   logic [1:0]          w_mode_inc;
   mode_e               w_mode_nxt;
   logic [3:0]          w_step_nxt;
   logic [3:0]          w_onehot_nxt;
   logic                w_dir_down_nxt;
   logic [PWM_BITS-1:0] w_duty_nxt;
   logic                w_pwm_on;
   logic [3:0]          w_led_nxt;
   logic                w_unused;

   assign w_tick      = bus.CSCounter[TICK_BIT] & ~r_tick_prev;
`ifdef LED_SEQ_HOLD_EN
   assign w_tick_eff  = w_tick & ~bus.Hold;
`else
   assign w_tick_eff  = w_tick;
`endif
   assign w_db_diff   = r_sync2 ^ r_db_level;
   assign w_db_accept = w_db_diff & (r_db_cnt == CNT_LAST);
   assign w_mode_adv  = w_db_accept & r_sync2;
   assign w_mode_inc  = r_mode + 2'd1;
   assign w_pwm_on    = bus.CSCounter[PWM_BITS-1:0] < r_duty;
   assign w_unused    = ^bus.CSCounter;

   // Button synchroniser, debouncer and tick edge tracking
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         r_sync1     <= 1'b0;
         r_sync2     <= 1'b0;
         r_db_level  <= 1'b0;
         r_db_cnt    <= '0;
         r_tick_prev <= 1'b0;
      end else begin
         r_sync1     <= bus.ModeButton;
         r_sync2     <= r_sync1;
         r_tick_prev <= bus.CSCounter[TICK_BIT];
         if (w_db_accept) begin
            r_db_level <= r_sync2;
            r_db_cnt   <= '0;
         end else if (w_db_diff) begin
            r_db_cnt   <= r_db_cnt + CNT_W'(1);
         end else begin
            r_db_cnt   <= '0;
         end
      end
   end

   // Mode and pattern state register
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         r_mode     <= MODE_BINARY;
         r_step     <= 4'd0;
         r_onehot   <= 4'b0001;
         r_dir_down <= 1'b0;
         r_duty     <= '0;
         r_led      <= 4'd0;
      end else begin
         r_mode     <= w_mode_nxt;
         r_step     <= w_step_nxt;
         r_onehot   <= w_onehot_nxt;
         r_dir_down <= w_dir_down_nxt;
         r_duty     <= w_duty_nxt;
         r_led      <= w_led_nxt;
      end
   end

   // Next mode/pattern state; a mode change discards a coincident tick
   always_comb begin
      w_mode_nxt     = r_mode;
      w_step_nxt     = r_step;
      w_onehot_nxt   = r_onehot;
      w_dir_down_nxt = r_dir_down;
      w_duty_nxt     = r_duty;
      if (w_mode_adv) begin
         w_mode_nxt     = mode_e'(w_mode_inc);
         w_step_nxt     = 4'd0;
         w_onehot_nxt   = 4'b0001;
         w_dir_down_nxt = 1'b0;
         w_duty_nxt     = '0;
      end else if (w_tick_eff) begin
         case (r_mode)
            MODE_BINARY: w_step_nxt = r_step + 4'd1;
            MODE_CHASE:  w_onehot_nxt = {r_onehot[2:0], r_onehot[3]};
            MODE_BOUNCE: begin
               if (r_dir_down) begin
                  w_onehot_nxt = {1'b0, r_onehot[3:1]};
                  if (w_onehot_nxt == 4'b0001) w_dir_down_nxt = 1'b0;
               end else begin
                  w_onehot_nxt = {r_onehot[2:0], 1'b0};
                  if (w_onehot_nxt == 4'b1000) w_dir_down_nxt = 1'b1;
               end
            end
            MODE_BREATHE: begin
               if (r_dir_down) begin
                  w_duty_nxt = r_duty - PWM_BITS'(1);
                  if (w_duty_nxt == '0) w_dir_down_nxt = 1'b0;
               end else begin
                  w_duty_nxt = r_duty + PWM_BITS'(1);
                  if (w_duty_nxt == DUTY_MAX) w_dir_down_nxt = 1'b1;
               end
            end
         endcase
      end
   end

   // LED image of the current state, registered one edge later
   always_comb begin
      w_led_nxt = 4'd0;
      case (r_mode)
         MODE_BINARY:  w_led_nxt = r_step;
         MODE_CHASE:   w_led_nxt = r_onehot;
         MODE_BOUNCE:  w_led_nxt = r_onehot;
         MODE_BREATHE: w_led_nxt = {4{w_pwm_on}};
      endcase
   end

   assign bus.LED1 = r_led[0];
   assign bus.LED2 = r_led[1];
   assign bus.LED3 = r_led[2];
   assign bus.LED4 = r_led[3];
   assign bus.Mode = r_mode;
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer (TICK_BIT=2, PWM_BITS=3, DEBOUNCE_CYCLES=4).
// Covers the Hold path when LED_SEQ_HOLD_EN is defined.
module tb_led_pattern_sequencer;
   logic       Clock;
   logic       Reset;
   logic [3:0] w_led;
   int         n_checks;
   int         n_pass;

   localparam logic [3:0] CHASE_SEQ  [0:3] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
   localparam logic [3:0] BOUNCE_SEQ [0:6] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                                               4'b0010, 4'b0001, 4'b0010};
   // Window samples taken at counter residues 5,6,7,0,1,2,3,4 (bit i = sample i)
   localparam logic [7:0] BREATHE_MASK [0:14] = '{8'h08, 8'h18, 8'h38, 8'h78, 8'hF8,
                                                  8'hF9, 8'hFB, 8'hF9, 8'hF8, 8'h78,
                                                  8'h38, 8'h18, 8'h08, 8'h00, 8'h08};

   led_pattern_sequencer_if bus ();

   led_pattern_sequencer #(
      .TICK_BIT        (2),
      .PWM_BITS        (3),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   assign w_led = {bus.LED4, bus.LED3, bus.LED2, bus.LED1};

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   // One clock edge, then advance the free-running counter
   task automatic cyc();
      @(posedge Clock);
      #1;
      bus.CSCounter = bus.CSCounter + 32'd1;
   endtask

   task automatic align(input logic [2:0] v);
      for (int i = 0; i < 8 && bus.CSCounter[2:0] != v; i++) cyc();
   endtask

   // Run through the next tick edge plus one edge so the LEDs show the new state
   task automatic next_tick_leds();
      align(3'd4);
      cyc();
      cyc();
   endtask

   // Six-cycle press starting at residue v; returns just after the mode-change edge (residue v+5)
   task automatic press_button(input logic [2:0] v);
      align(v);
      bus.ModeButton = 1'b1;
      repeat (6) cyc();
      bus.ModeButton = 1'b0;
   endtask

   task automatic duty_window(output logic [7:0] mask);
      align(3'd5);
      for (int i = 0; i < 8; i++) begin
         cyc();
         mask[i] = (w_led == 4'hF);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation ran past its time limit");
      $fatal(1);
   end

   initial begin
      logic [7:0] mask;
      n_checks       = 0;
      n_pass         = 0;
      Reset          = 1'b0;
      bus.CSCounter  = 32'd0;
      bus.ModeButton = 1'b0;
`ifdef LED_SEQ_HOLD_EN
      bus.Hold       = 1'b0;
`endif
      repeat (3) cyc();
      chk("reset_leds", 32'(w_led), 32'h0);
      chk("reset_mode", 32'(bus.Mode), 32'h0);

      Reset         = 1'b1;
      bus.CSCounter = 32'd0;
      cyc();
      chk("release_leds", 32'(w_led), 32'h0);
      chk("release_mode", 32'(bus.Mode), 32'h0);

      for (int i = 1; i <= 16; i++) begin
         next_tick_leds();
         chk($sformatf("binary_%0d", i), 32'(w_led), 32'(i % 16));
      end

      press_button(3'd0);
      chk("chase_mode", 32'(bus.Mode), 32'd1);
      cyc();
      chk("chase_init", 32'(w_led), 32'h1);
      for (int i = 0; i < 4; i++) begin
         next_tick_leds();
         chk($sformatf("chase_%0d", i), 32'(w_led), 32'(CHASE_SEQ[i]));
      end
      chk("chase_mode_once", 32'(bus.Mode), 32'd1);

      align(3'd0);
      bus.ModeButton = 1'b1;
      repeat (2) cyc();
      bus.ModeButton = 1'b0;
      repeat (8) cyc();
      chk("glitch_mode", 32'(bus.Mode), 32'd1);

      press_button(3'd0);
      chk("bounce_mode", 32'(bus.Mode), 32'd2);
      cyc();
      chk("bounce_init", 32'(w_led), 32'h1);
      for (int i = 0; i < 7; i++) begin
         next_tick_leds();
         chk($sformatf("bounce_%0d", i), 32'(w_led), 32'(BOUNCE_SEQ[i]));
      end

      press_button(3'd0);
      chk("breathe_mode", 32'(bus.Mode), 32'd3);
      for (int k = 0; k < 15; k++) begin
         duty_window(mask);
         chk($sformatf("breathe_win_%0d", k), 32'(mask), 32'(BREATHE_MASK[k]));
      end

      // Mode change lands exactly on a tick edge (residue 4)
      press_button(3'd7);
      chk("adv_on_tick_mode", 32'(bus.Mode), 32'd0);
      cyc();
      chk("adv_on_tick_init", 32'(w_led), 32'h0);
      repeat (5) cyc();
      chk("adv_on_tick_discard", 32'(w_led), 32'h0);
      next_tick_leds();
      chk("adv_then_tick", 32'(w_led), 32'h1);

      // Previous edge saw bit2=1, so jumping to all-ones then wrapping must not step
      bus.CSCounter = 32'hFFFF_FFFF;
      cyc();
      chk("wrap_at_ones", 32'(w_led), 32'h1);
      repeat (4) cyc();
      chk("wrap_no_step", 32'(w_led), 32'h1);
      next_tick_leds();
      chk("wrap_next_tick", 32'(w_led), 32'h2);

      press_button(3'd0);
      chk("mid_mode1", 32'(bus.Mode), 32'd1);
      repeat (8) cyc();
      bus.ModeButton = 1'b1;
      repeat (8) cyc();
      chk("mid_mode2", 32'(bus.Mode), 32'd2);
      Reset = 1'b0;
      cyc();
      Reset = 1'b1;
      chk("mid_reset_mode", 32'(bus.Mode), 32'd0);
      chk("mid_reset_leds", 32'(w_led), 32'h0);
      repeat (2) cyc();
      chk("held_not_yet", 32'(bus.Mode), 32'd0);
      repeat (6) cyc();
      chk("held_redebounce", 32'(bus.Mode), 32'd1);
      bus.ModeButton = 1'b0;
      repeat (8) cyc();

      Reset = 1'b0;
      cyc();
      Reset = 1'b1;
      repeat (3) next_tick_leds();
      chk("pre_hold_step3", 32'(w_led), 32'h3);
`ifdef LED_SEQ_HOLD_EN
      bus.Hold = 1'b1;
      for (int i = 0; i < 5; i++) begin
         next_tick_leds();
         chk($sformatf("hold_%0d", i), 32'(w_led), 32'h3);
      end
      bus.Hold = 1'b0;
      repeat (2) cyc();
      chk("hold_no_catchup", 32'(w_led), 32'h3);
      next_tick_leds();
      chk("hold_release_tick", 32'(w_led), 32'h4);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
